// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 output display: segment encodings and the
// conversion FSM state type.
package sap_pkg;

  // Active-high encodings, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sap_bin2bcd.sv
// Sequential double-dabble: 8-bit magnitude to 10-bit BCD in 8 shift edges
// plus one DONE edge. A start pulse in any state restarts from scratch.
module sap_bin2bcd
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mag,
  output logic       busy,
  output logic       done,
  output logic [9:0] bcd
);

  conv_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [17:0] shreg_q, shreg_d;

  // Hundreds can never exceed 2 for an 8-bit input, so only tens/ones need add-3
  function automatic logic [17:0] dabble_step(input logic [17:0] s);
    logic [17:0] t;
    t = s;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[16:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (start) begin
      state_d = CONV;
      cnt_d   = 3'd0;
      shreg_d = {10'd0, mag};
    end else begin
      case (state_q)
        CONV: begin
          shreg_d = dabble_step(shreg_q);
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 18'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = shreg_q[17:8];

endmodule

// File: rtl/sap_out_display.sv
// SAP-1 output port: latches the bus on Lo, converts to decimal in the
// background and scans the result onto a 4-digit 7-segment display.
module sap_out_display
  import sap_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic [7:0] DATA,
  input  logic       load,
  input  logic       signed_mode,
  output logic [7:0] out_reg,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] dig_en
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [7:0]    out_reg_q, out_reg_d;
  logic          mode_q, mode_d;
  logic          neg_pending_q, neg_pending_d;
  logic [1:0]    hund_q, hund_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_en_q, dig_en_d;

  logic       conv_busy, conv_done, start;
  logic [7:0] src, mag;
  logic       src_neg;
  logic [9:0] bcd;

  // Mode changes only retrigger from IDLE; a load always wins and restarts
  always_comb begin
    start   = load | (~conv_busy & (signed_mode != mode_q));
    src     = load ? DATA : out_reg_q;
    src_neg = signed_mode & src[7];
    mag     = src_neg ? (~src + 8'd1) : src;
  end

  sap_bin2bcd u_bin2bcd (
    .clk   (CLK),
    .rst_n (CLR_n),
    .start (start),
    .mag   (mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    out_reg_d     = load ? DATA : out_reg_q;
    mode_d        = signed_mode;
    neg_pending_d = start ? src_neg : neg_pending_q;
    hund_d        = hund_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    neg_d         = neg_q;
    // A restart on the DONE edge discards the stale result
    if (conv_done && !start) begin
      hund_d = bcd[9:8];
      tens_d = bcd[7:4];
      ones_d = bcd[3:0];
      neg_d  = neg_pending_q;
    end
  end

  always_comb begin
    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    idx_d = (pre_q == PRE_LAST) ? idx_q + 2'd1 : idx_q;
    dig_en_d = 4'b0001 << idx_q;
    case (idx_q)
      2'd3:    seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
      2'd2:    seg_d = (hund_q == 2'd0) ? SEG_BLANK : seg_of_digit({2'b00, hund_q});
      2'd1:    seg_d = (hund_q == 2'd0 && tens_q == 4'd0) ? SEG_BLANK : seg_of_digit(tens_q);
      default: seg_d = seg_of_digit(ones_q);
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      out_reg_q     <= 8'd0;
      mode_q        <= 1'b0;
      neg_pending_q <= 1'b0;
      hund_q        <= 2'd0;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      neg_q         <= 1'b0;
      pre_q         <= '0;
      idx_q         <= 2'd0;
      seg_q         <= 7'd0;
      dig_en_q      <= 4'd0;
    end else begin
      out_reg_q     <= out_reg_d;
      mode_q        <= mode_d;
      neg_pending_q <= neg_pending_d;
      hund_q        <= hund_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      neg_q         <= neg_d;
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      seg_q         <= seg_d;
      dig_en_q      <= dig_en_d;
    end
  end

  assign out_reg = out_reg_q;
  assign busy    = conv_busy;
  assign seg     = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dig_en  = DIG_ACTIVE_LOW ? ~dig_en_q : dig_en_q;

endmodule

// File: tb/tb_sap_out_display.sv
// Directed bench for sap_out_display with fast scanning and active-high
// outputs; expected segment patterns are hand-computed.
module tb_sap_out_display;

  logic       CLK;
  logic       CLR_n;
  logic [7:0] DATA;
  logic       load;
  logic       signed_mode;
  logic [7:0] out_reg;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] dig_en;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] dg [4];
  int   blen;
  logic seen7;

  sap_out_display #(
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .CLK         (CLK),
    .CLR_n       (CLR_n),
    .DATA        (DATA),
    .load        (load),
    .signed_mode (signed_mode),
    .out_reg     (out_reg),
    .busy        (busy),
    .seg         (seg),
    .dig_en      (dig_en)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present d for one rising edge; returns on the negedge after that edge
  task automatic drive_load(input logic [7:0] d);
    @(negedge CLK);
    DATA = d;
    load = 1'b1;
    @(negedge CLK);
    load = 1'b0;
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge CLK);
    chk("idle_timeout", busy, 1'b0);
    @(negedge CLK);
  endtask

  task automatic check_disp(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    for (int i = 0; i < 4; i++) dg[i] = 7'h55;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) if (dig_en[i]) dg[i] = seg;
    end
    chk({tag, "_d3"}, dg[3], e3);
    chk({tag, "_d2"}, dg[2], e2);
    chk({tag, "_d1"}, dg[1], e1);
    chk({tag, "_d0"}, dg[0], e0);
  endtask

  initial begin
    CLR_n       = 1'b0;
    DATA        = 8'h00;
    load        = 1'b0;
    signed_mode = 1'b0;
    #1;
    chk("rst_out_reg", out_reg, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dig_en", dig_en, 4'b0000);
    #22 CLR_n = 1'b1;

    // Asynchronous reset in the middle of a conversion and a scan slot
    drive_load(8'h33);
    repeat (3) @(posedge CLK);
    #2 CLR_n = 1'b0;
    #1;
    chk("arst_out_reg", out_reg, 8'h00);
    chk("arst_busy", busy, 1'b0);
    @(negedge CLK);
    CLR_n = 1'b1;

    // Scan rotation from a known phase, with a conversion in flight
    for (int n = 1; n <= 20; n++) begin
      logic [3:0] e;
      if (n == 6) begin
        DATA = 8'h05;
        load = 1'b1;
      end
      @(posedge CLK);
      #1;
      load = 1'b0;
      e = 4'b0001 << (((n - 1) / 4) % 4);
      chk("scan_dig_en", dig_en, e);
      chk("scan_onehot", $onehot(dig_en), 1'b1);
      if (n == 1) chk("rst_seg", seg, 7'h3F);
      if (n == 8) chk("scan_busy", busy, 1'b1);
    end
    wait_idle();
    check_disp("five", 7'h00, 7'h00, 7'h00, 7'h6D);

    // Unsigned 255
    drive_load(8'hFF);
    chk("ff_out_reg", out_reg, 8'hFF);
    busy_len(blen);
    chk("ff_busy_len", blen, 9);
    wait_idle();
    check_disp("u255", 7'h00, 7'h5B, 7'h6D, 7'h6D);

    // Mode toggle in IDLE reinterprets the latched byte
    @(negedge CLK);
    signed_mode = 1'b1;
    @(negedge CLK);
    busy_len(blen);
    chk("tog_busy_len", blen, 9);
    wait_idle();
    check_disp("s_m1", 7'h40, 7'h00, 7'h00, 7'h06);
    @(negedge CLK);
    signed_mode = 1'b0;
    @(negedge CLK);
    busy_len(blen);
    chk("untog_busy_len", blen, 9);
    wait_idle();
    check_disp("u255b", 7'h00, 7'h5B, 7'h6D, 7'h6D);

    // Signed loads
    @(negedge CLK);
    signed_mode = 1'b1;
    @(negedge CLK);
    wait_idle();
    drive_load(8'h80);
    wait_idle();
    check_disp("s_m128", 7'h40, 7'h06, 7'h5B, 7'h7F);
    drive_load(8'hF6);
    wait_idle();
    check_disp("s_m10", 7'h40, 7'h00, 7'h06, 7'h3F);

    // Abort: the first conversion must never reach the display
    fork
      begin
        seen7 = 1'b0;
        repeat (30) begin
          @(negedge CLK);
          if (dig_en == 4'b0001 && seg == 7'h07) seen7 = 1'b1;
        end
      end
      begin
        drive_load(8'h07);
        @(negedge CLK);
        chk("abort_busy_mid", busy, 1'b1);
        drive_load(8'h2A);
        busy_len(blen);
        chk("abort_busy_len", blen, 9);
      end
    join
    chk("abort_no7", seen7, 1'b0);
    chk("abort_out_reg", out_reg, 8'h2A);
    wait_idle();
    check_disp("u42", 7'h00, 7'h00, 7'h66, 7'h5B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
